uci_host: RTL
=============

Name: uci_host

Overview:
- GUI-side counterpart of the engine's UCI command interface.
- Turns compact command requests (new game, play move, go) into ASCII UCI command lines on a character stream toward the engine.
- Parses the engine's reply stream and extracts `bestmove` lines into a `move_t`. All other lines (`info`, `id`, `uciok`) are discarded.
- Sits between the board/UI controller and the engine's character link (UART or direct loopback for self-play).

Parameters:
- MAX_LINE, 64, receive chars per line before the rest of the line is discarded (minimum 16).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- cmd_in  input  2  0=NEW_GAME, 1=MOVE, 2=GO, 3=reserved (accepted, emits nothing)
- cmd_move_in  input  move_t  move for MOVE command
- cmd_valid  input  1  command request
- cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready
- engine_busy  output  1  high from GO acceptance until bestmove parsed
- char_out  output  8  ASCII char to engine
- char_out_valid  output  1  char_out valid
- char_out_ready  input  1  engine/link accepts char
- char_in  input  8  ASCII char from engine
- char_in_valid  input  1  char_in valid
- char_in_ready  output  1  constant 1
- best_move_out  output  move_t  parsed engine move
- best_move_valid  output  1  one-cycle pulse with best_move_out
- parse_error  output  1  one-cycle pulse on malformed bestmove line

Behaviour:
- Reset values: char_out=0, char_out_valid=0, cmd_ready=0, engine_busy=0, best_move_out=0, best_move_valid=0, parse_error=0. TX buffer and RX parser are cleared. Reset mid-line aborts both directions immediately.
- cmd_ready = TX idle && !engine_busy (and handshake done, if the optional feature is enabled). Registered; first goes high the cycle after reset deasserts.

TX (registered, states TX_IDLE, TX_SEND):
- On accept in cycle N, load an 18-byte shift buffer. char_out_valid=1 with the first char in cycle N+1.
- NEW_GAME sends "position startpos\n". MOVE sends "move " + src.fil+'a', src.rnk+'1', dst.fil+'a', dst.rnk+'1', optional promo char n/b/r/q, then '\n'. GO sends "go\n" and sets engine_busy.
- special=SPECIAL_NONE or SPECIAL_UNKNOWN appends no promo char.
- char_out and char_out_valid hold stable until char_out_ready. Shift on each handshake; no bubbles between chars.
- After '\n' is accepted, return to TX_IDLE. cmd_ready rises in the following cycle.

RX (states RX_PREFIX, RX_MOVE, RX_SKIP):
- RX_PREFIX: match "bestmove " char-by-char with index 0..8. A mismatch goes to RX_SKIP. A '\n' in RX_PREFIX resets the index (empty or short lines are ignored). Index 9 goes to RX_MOVE.
- RX_MOVE: capture up to 5 chars. Terminator is '\n' or ' '.
  - A ' ' terminator completes the move, then skips the rest of the line (e.g. "ponder").
  - On terminator with 4 chars: files 'a'..'h' and ranks '1'..'8' must be valid. Then pulse best_move_valid the next cycle with special=SPECIAL_NONE.
  - On terminator with 5 chars: the 5th char n/b/r/q maps to SPECIAL_PROMOTE_KNIGHT/BISHOP/ROOK/QUEEN.
  - Any other count, range violation, or a 6th char: pulse parse_error instead, no best_move_valid.
- Either pulse clears engine_busy in the same cycle as the pulse.
- RX_SKIP: discard until '\n', then go to RX_PREFIX. A line longer than MAX_LINE chars in any state forces RX_SKIP.
- The engine applies its own bestmove internally. The host never re-sends it; that is the controller's responsibility.
- TX and RX are independent. A command accept and an RX terminator in the same cycle are both honoured. A bestmove arriving while engine_busy=0 is still reported.

Optional Feature:
UCI_HOST_HANDSHAKE_EN:
- Defined: after reset, TX automatically sends "uci\n". cmd_ready stays 0 until an RX line exactly equal to "uciok" is terminated by '\n'; it rises the next cycle.
- A line prefix mismatch still skips to line end, but RX also tracks the "uciok" match in parallel.
- Undefined: no auto-send. cmd_ready rises one cycle after reset. "uciok" lines are discarded like any other non-bestmove line.

Test Plan:
- NEW_GAME with char_out_ready=1 -> 18 consecutive chars "position startpos\n" starting the cycle after accept; cmd_ready returns after '\n'.
- MOVE src=(4,1) dst=(4,3) SPECIAL_NONE, then MOVE src=(0,6) dst=(0,7) SPECIAL_PROMOTE_QUEEN, with char_out_ready toggling every cycle -> "move e2e4\n" then "move a7a8q\n"; chars held stable while ready=0.
- GO, then RX feeds "info depth 3\nbestmove g1f3\n" -> "go\n" sent, engine_busy=1; exactly one best_move_valid with src=(6,0) dst=(5,2) SPECIAL_NONE; engine_busy=0 in the pulse cycle; cmd_ready=1 the cycle after.
- RX "bestmove e7e8x\n" and "bestmove i2i4\n" -> parse_error pulse each, no best_move_valid; RX "bestmove b7b8n ponder a1a2\n" -> best_move_out src=(1,6) dst=(1,7) SPECIAL_PROMOTE_KNIGHT.
- Assert rst_in mid "position startpos" -> char_out_valid=0 next cycle; a following GO emits a clean "go\n".
- With UCI_HOST_HANDSHAKE_EN: reset -> "uci\n" emitted, cmd_ready=0 through "id name River\n"; cmd_ready=1 one cycle after "uciok\n".

Source files
------------

// File: rtl/uci_host.sv
// UCI host: serialises NEW_GAME/MOVE/GO requests into UCI text lines and extracts
// "bestmove" replies into move_t. Define UCI_HOST_HANDSHAKE_EN for the "uci"/"uciok" start-up handshake.
package uci_host_pkg;
  typedef struct packed {
    logic [2:0] fil;
    logic [2:0] rnk;
  } square_t;

  typedef enum logic [2:0] {
    SPECIAL_NONE           = 3'd0,
    SPECIAL_PROMOTE_KNIGHT = 3'd1,
    SPECIAL_PROMOTE_BISHOP = 3'd2,
    SPECIAL_PROMOTE_ROOK   = 3'd3,
    SPECIAL_PROMOTE_QUEEN  = 3'd4,
    SPECIAL_UNKNOWN        = 3'd7
  } special_t;

  typedef struct packed {
    square_t  src;
    square_t  dst;
    special_t special;
  } move_t;
endpackage

module uci_host
  import uci_host_pkg::*;
#(
  parameter int MAX_LINE = 64
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [1:0] cmd_in,
  input  move_t      cmd_move_in,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       engine_busy,
  output logic [7:0] char_out,
  output logic       char_out_valid,
  input  logic       char_out_ready,
  input  logic [7:0] char_in,
  input  logic       char_in_valid,
  output logic       char_in_ready,
  output move_t      best_move_out,
  output logic       best_move_valid,
  output logic       parse_error
);

  localparam int LW = $clog2(MAX_LINE + 1);
  localparam logic [7:0] LF = 8'h0a;

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
  typedef enum logic [1:0] {RX_PREFIX, RX_MOVE, RX_SKIP} rx_state_t;

  function automatic logic [7:0] sq_char(input logic [2:0] v, input logic [7:0] base);
    return base + {5'd0, v};
  endfunction

  function automatic logic [2:0] low3(input logic [7:0] c, input logic [7:0] base);
    logic [7:0] t;
    t = c - base;
    return t[2:0];
  endfunction

  function automatic logic file_ok(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h68);
  endfunction

  function automatic logic rank_ok(input logic [7:0] c);
    return (c >= 8'h31) && (c <= 8'h38);
  endfunction

  function automatic logic [7:0] prefix_char(input logic [3:0] i);
    case (i)
      4'd0:    return "b";
      4'd1:    return "e";
      4'd2:    return "s";
      4'd3:    return "t";
      4'd4:    return "m";
      4'd5:    return "o";
      4'd6:    return "v";
      4'd7:    return "e";
      default: return " ";
    endcase
  endfunction

  // TX state
  tx_state_t    tx_state_q, tx_state_d;
  logic [143:0] tx_buf_q, tx_buf_d;
  logic [4:0]   tx_cnt_q, tx_cnt_d;
  logic         busy_d, cmd_ready_d, cmd_accept;
  logic         has_promo;
  logic [7:0]   promo_ch;
  logic [31:0]  move_sq;

  // RX state
  rx_state_t    rx_state_q, rx_state_d;
  logic [3:0]   pidx_q, pidx_d;
  logic [2:0]   mcnt_q, mcnt_d;
  logic [39:0]  mbuf_q, mbuf_d;
  logic [LW-1:0] line_len_q, line_len_d;
  move_t        bm_d, cand;
  logic         bm_valid_d, perr_d, rx_pulse;
  logic         is_lf, is_term, coords_ok, promo_ok;
  logic [31:0]  m4;
  special_t     promo_sp;

`ifdef UCI_HOST_HANDSHAKE_EN
  logic       hs_sent_q, hs_sent_d, hs_done_q, hs_done_d, hs_bad_q, hs_bad_d;
  logic [2:0] hs_cnt_q, hs_cnt_d;

  function automatic logic [7:0] uciok_char(input logic [2:0] i);
    case (i)
      3'd0:    return "u";
      3'd1:    return "c";
      3'd2:    return "i";
      3'd3:    return "o";
      default: return "k";
    endcase
  endfunction
`endif

  assign char_out       = tx_buf_q[143:136];
  assign char_out_valid = (tx_state_q == TX_SEND);
  assign char_in_ready  = 1'b1;
  assign rx_pulse       = bm_valid_d || perr_d;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_buf_d   = tx_buf_q;
    tx_cnt_d   = tx_cnt_q;
    busy_d     = engine_busy;
    cmd_accept = cmd_valid && cmd_ready;
    has_promo  = 1'b1;
    promo_ch   = "q";
    case (cmd_move_in.special)
      SPECIAL_PROMOTE_KNIGHT: promo_ch = "n";
      SPECIAL_PROMOTE_BISHOP: promo_ch = "b";
      SPECIAL_PROMOTE_ROOK:   promo_ch = "r";
      SPECIAL_PROMOTE_QUEEN:  promo_ch = "q";
      default:                has_promo = 1'b0;
    endcase
    move_sq = {sq_char(cmd_move_in.src.fil, "a"), sq_char(cmd_move_in.src.rnk, "1"),
               sq_char(cmd_move_in.dst.fil, "a"), sq_char(cmd_move_in.dst.rnk, "1")};
`ifdef UCI_HOST_HANDSHAKE_EN
    hs_sent_d = hs_sent_q;
`endif
    if (tx_state_q == TX_SEND) begin
      if (char_out_ready) begin
        tx_buf_d = {tx_buf_q[135:0], 8'h00};
        tx_cnt_d = tx_cnt_q - 5'd1;
        if (tx_cnt_q == 5'd1) tx_state_d = TX_IDLE;
      end
    end
`ifdef UCI_HOST_HANDSHAKE_EN
    else if (!hs_sent_q) begin
      tx_buf_d   = {"uci", LF, 112'd0};
      tx_cnt_d   = 5'd4;
      tx_state_d = TX_SEND;
      hs_sent_d  = 1'b1;
    end
`endif
    else if (cmd_accept) begin
      case (cmd_in)
        2'd0: begin
          tx_buf_d   = {"position startpos", LF};
          tx_cnt_d   = 5'd18;
          tx_state_d = TX_SEND;
        end
        2'd1: begin
          if (has_promo) begin
            tx_buf_d = {"move ", move_sq, promo_ch, LF, 56'd0};
            tx_cnt_d = 5'd11;
          end else begin
            tx_buf_d = {"move ", move_sq, LF, 64'd0};
            tx_cnt_d = 5'd10;
          end
          tx_state_d = TX_SEND;
        end
        2'd2: begin
          tx_buf_d   = {"go", LF, 120'd0};
          tx_cnt_d   = 5'd3;
          tx_state_d = TX_SEND;
        end
        default: ;
      endcase
    end
    if (rx_pulse) busy_d = 1'b0;
    if (cmd_accept && (cmd_in == 2'd2)) busy_d = 1'b1;
    cmd_ready_d = (tx_state_d == TX_IDLE) && !busy_d;
`ifdef UCI_HOST_HANDSHAKE_EN
    cmd_ready_d = cmd_ready_d && hs_sent_d && hs_done_d;
`endif
  end

  // With five captured chars the coordinates sit one byte higher than with four.
  always_comb begin
    rx_state_d = rx_state_q;
    pidx_d     = pidx_q;
    mcnt_d     = mcnt_q;
    mbuf_d     = mbuf_q;
    line_len_d = line_len_q;
    bm_d       = best_move_out;
    bm_valid_d = 1'b0;
    perr_d     = 1'b0;
    is_lf      = (char_in == LF);
    is_term    = is_lf || (char_in == " ");
    m4         = (mcnt_q == 3'd5) ? mbuf_q[39:8] : mbuf_q[31:0];
    coords_ok  = file_ok(m4[31:24]) && rank_ok(m4[23:16]) && file_ok(m4[15:8]) && rank_ok(m4[7:0]);
    promo_ok   = 1'b1;
    promo_sp   = SPECIAL_NONE;
    case (mbuf_q[7:0])
      "n":     promo_sp = SPECIAL_PROMOTE_KNIGHT;
      "b":     promo_sp = SPECIAL_PROMOTE_BISHOP;
      "r":     promo_sp = SPECIAL_PROMOTE_ROOK;
      "q":     promo_sp = SPECIAL_PROMOTE_QUEEN;
      default: promo_ok = 1'b0;
    endcase
    cand.src.fil = low3(m4[31:24], "a");
    cand.src.rnk = low3(m4[23:16], "1");
    cand.dst.fil = low3(m4[15:8], "a");
    cand.dst.rnk = low3(m4[7:0], "1");
    cand.special = (mcnt_q == 3'd5) ? promo_sp : SPECIAL_NONE;
    if (char_in_valid) begin
      if (is_lf) line_len_d = '0;
      else if (line_len_q != LW'(MAX_LINE)) line_len_d = line_len_q + 1'b1;
      if (!is_lf && (line_len_q == LW'(MAX_LINE))) begin
        rx_state_d = RX_SKIP;
        pidx_d     = '0;
      end else begin
        case (rx_state_q)
          RX_PREFIX: begin
            if (is_lf) pidx_d = '0;
            else if (char_in == prefix_char(pidx_q)) begin
              if (pidx_q == 4'd8) begin
                rx_state_d = RX_MOVE;
                pidx_d     = '0;
                mcnt_d     = '0;
              end else begin
                pidx_d = pidx_q + 4'd1;
              end
            end else begin
              rx_state_d = RX_SKIP;
              pidx_d     = '0;
            end
          end
          RX_MOVE: begin
            if (is_term) begin
              if (coords_ok && ((mcnt_q == 3'd4) || ((mcnt_q == 3'd5) && promo_ok))) begin
                bm_valid_d = 1'b1;
                bm_d       = cand;
              end else begin
                perr_d = 1'b1;
              end
              rx_state_d = is_lf ? RX_PREFIX : RX_SKIP;
              mcnt_d     = '0;
            end else if (mcnt_q == 3'd5) begin
              perr_d     = 1'b1;
              rx_state_d = RX_SKIP;
              mcnt_d     = '0;
            end else begin
              mbuf_d = {mbuf_q[31:0], char_in};
              mcnt_d = mcnt_q + 3'd1;
            end
          end
          default: begin
            if (is_lf) begin
              rx_state_d = RX_PREFIX;
              pidx_d     = '0;
            end
          end
        endcase
      end
    end
  end

`ifdef UCI_HOST_HANDSHAKE_EN
  // "uciok" is tracked beside the bestmove parser so a skipped line can still unlock commands.
  always_comb begin
    hs_cnt_d  = hs_cnt_q;
    hs_bad_d  = hs_bad_q;
    hs_done_d = hs_done_q;
    if (char_in_valid) begin
      if (is_lf) begin
        if (!hs_bad_q && (hs_cnt_q == 3'd5)) hs_done_d = 1'b1;
        hs_cnt_d = '0;
        hs_bad_d = 1'b0;
      end else if (!hs_bad_q && (hs_cnt_q < 3'd5) && (char_in == uciok_char(hs_cnt_q))) begin
        hs_cnt_d = hs_cnt_q + 3'd1;
      end else begin
        hs_bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hs_sent_q <= 1'b0;
      hs_done_q <= 1'b0;
      hs_bad_q  <= 1'b0;
      hs_cnt_q  <= '0;
    end else begin
      hs_sent_q <= hs_sent_d;
      hs_done_q <= hs_done_d;
      hs_bad_q  <= hs_bad_d;
      hs_cnt_q  <= hs_cnt_d;
    end
  end
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_state_q      <= TX_IDLE;
      tx_buf_q        <= '0;
      tx_cnt_q        <= '0;
      engine_busy     <= 1'b0;
      cmd_ready       <= 1'b0;
      rx_state_q      <= RX_PREFIX;
      pidx_q          <= '0;
      mcnt_q          <= '0;
      mbuf_q          <= '0;
      line_len_q      <= '0;
      best_move_out   <= '0;
      best_move_valid <= 1'b0;
      parse_error     <= 1'b0;
    end else begin
      tx_state_q      <= tx_state_d;
      tx_buf_q        <= tx_buf_d;
      tx_cnt_q        <= tx_cnt_d;
      engine_busy     <= busy_d;
      cmd_ready       <= cmd_ready_d;
      rx_state_q      <= rx_state_d;
      pidx_q          <= pidx_d;
      mcnt_q          <= mcnt_d;
      mbuf_q          <= mbuf_d;
      line_len_q      <= line_len_d;
      best_move_out   <= bm_d;
      best_move_valid <= bm_valid_d;
      parse_error     <= perr_d;
    end
  end

endmodule
